cover_toggle_sched: RTL and testbench

Scheduler for one toggle-coverage group of `WIDTH` points. It captures per-cycle hit vectors into a sticky covered bitmap and forwards only first-time hits. Those hits leave as a serialized valid/ready stream of global cover indices, one per cycle at most. It sits between the toggle-coverage probes and a single shared coverage sink (DPI bridge or hardware counter), so the sink never sees more than one call per cycle or any duplicate index.

---
 rtl/cover_pkg.sv | 24 ++
 rtl/cover_lsb_enc.sv | 20 ++
 rtl/cover_toggle_sched.sv | 102 ++++++++++
 tb/tb_cover_toggle_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared types and helpers for the toggle-coverage scheduler.
package cover_pkg;

  localparam int COVER_IDX_W = 64;
  // Widest hit vector the popcount helper accepts; callers zero-extend.
  localparam int POP_MAX_W = 256;

  typedef logic [COVER_IDX_W-1:0] cover_idx_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } cover_sched_state_e;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cover_lsb_enc.sv
// Lowest-set-bit priority encoder, purely combinational.
module cover_lsb_enc #(
  parameter int WIDTH = 36,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cover_toggle_sched.sv
// Captures toggle hits into a sticky bitmap and serialises first-time hits
// as a valid/ready stream of global cover indices, one per cycle at most.
module cover_toggle_sched
  import cover_pkg::*;
#(
  parameter int WIDTH       = 36,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8940,
  parameter int CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] valid,
  output logic             ev_valid,
  input  logic             ev_ready,
  output cover_idx_t       ev_index,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             pending_any,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
      $error("cover_toggle_sched: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end
    if (WIDTH > POP_MAX_W) begin : g_width_err
      $error("cover_toggle_sched: WIDTH exceeds popcount helper width");
    end
  endgenerate

  logic [WIDTH-1:0]   covered_reg, covered_next;
  logic [WIDTH-1:0]   pending_reg, pending_next;
  logic [WIDTH-1:0]   capture, new_hits, sel_mask;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  cover_sched_state_e state_reg, state_next;
  cover_idx_t         ev_index_reg, ev_index_next;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               load;

  cover_lsb_enc #(.WIDTH(WIDTH)) u_enc (
    .vec   (pending_reg),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    capture  = enable ? valid : '0;
    new_hits = capture & ~covered_reg;
    sel_mask = WIDTH'(1) << sel_idx;
    // Load whenever the output register is empty or being emptied this edge.
    load     = sel_found && ((state_reg == IDLE) || ev_ready);

    state_next    = state_reg;
    ev_index_next = ev_index_reg;
    if (load) begin
      state_next    = SEND;
      ev_index_next = cover_idx_t'(COVER_INDEX) + cover_idx_t'(sel_idx);
    end else if ((state_reg == SEND) && ev_ready) begin
      state_next = IDLE;
    end

    // Clear restarts the bitmaps from this cycle's capture alone; the loaded
    // bit is gone from pending either way.
    if (clear) begin
      covered_next = capture;
      pending_next = capture;
      cnt_next     = CNT_W'(popcount(POP_MAX_W'(capture)));
    end else begin
      covered_next = covered_reg | capture;
      pending_next = (pending_reg & ~(load ? sel_mask : '0)) | new_hits;
      cnt_next     = CNT_W'(32'(cnt_reg) + popcount(POP_MAX_W'(new_hits)));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      covered_reg  <= '0;
      pending_reg  <= '0;
      cnt_reg      <= '0;
      state_reg    <= IDLE;
      ev_index_reg <= '0;
    end else begin
      covered_reg  <= covered_next;
      pending_reg  <= pending_next;
      cnt_reg      <= cnt_next;
      state_reg    <= state_next;
      ev_index_reg <= ev_index_next;
    end
  end

  assign ev_valid    = (state_reg == SEND);
  assign ev_index    = ev_index_reg;
  assign covered_cnt = cnt_reg;
  assign pending_any = |pending_reg;
  assign done        = (cnt_reg == CNT_W'(WIDTH)) && !pending_any && !ev_valid;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Randomised and directed bench for cover_toggle_sched against a set-based model.
module tb_cover_toggle_sched;

  localparam int W    = 36;
  localparam int BASE = 100;
  localparam int CW   = $clog2(W + 1);

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic          clear;
  logic [W-1:0]  valid;
  logic          ev_valid;
  logic          ev_ready;
  logic [63:0]   ev_index;
  logic [CW-1:0] covered_cnt;
  logic          pending_any;
  logic          done;

  cover_toggle_sched #(
    .WIDTH       (W),
    .COVER_INDEX (BASE),
    .COVER_TOTAL (8940)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .valid       (valid),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_index    (ev_index),
    .covered_cnt (covered_cnt),
    .pending_any (pending_any),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: sets of covered / not-yet-sent points plus the event on offer.
  bit          m_cov  [W];
  bit          m_pend [W];
  int          m_cnt;
  bit          m_ev_valid;
  logic [63:0] m_ev_index;

  logic [63:0] acc_q[$];
  int          acc_cyc[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < W; i++) begin
      m_cov[i]  = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_cnt      = 0;
    m_ev_valid = 1'b0;
    m_ev_index = '0;
  endfunction

  function automatic bit model_any_pending();
    for (int i = 0; i < W; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit clr, input logic [W-1:0] v, input bit rdy);
    int low;
    low = -1;
    for (int i = 0; i < W; i++) if (m_pend[i] && low < 0) low = i;
    // The offered slot is free if empty or being accepted now.
    if (low >= 0 && (!m_ev_valid || rdy)) begin
      m_pend[low] = 1'b0;
      m_ev_valid  = 1'b1;
      m_ev_index  = 64'(BASE + low);
    end else if (m_ev_valid && rdy) begin
      m_ev_valid = 1'b0;
    end
    if (clr) begin
      m_cnt = 0;
      for (int i = 0; i < W; i++) begin
        m_cov[i]  = en && v[i];
        m_pend[i] = m_cov[i];
        if (m_cov[i]) m_cnt++;
      end
    end else if (en) begin
      for (int i = 0; i < W; i++) begin
        if (v[i] && !m_cov[i]) begin
          m_cov[i]  = 1'b1;
          m_pend[i] = 1'b1;
          m_cnt++;
        end
      end
    end
  endfunction

  task automatic compare_all();
    bit exp_done;
    exp_done = (m_cnt == W) && !model_any_pending() && !m_ev_valid;
    check_val("ev_valid", 64'(ev_valid), 64'(m_ev_valid));
    check_val("ev_index", ev_index, m_ev_index);
    check_val("covered_cnt", 64'(covered_cnt), 64'(m_cnt));
    check_val("pending_any", 64'(pending_any), 64'(model_any_pending()));
    check_val("done", 64'(done), 64'(exp_done));
  endtask

  task automatic tick();
    bit          acc;
    logic [63:0] aidx;
    acc  = ev_valid && ev_ready;
    aidx = ev_index;
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step(enable, clear, valid, ev_ready);
    #1;
    cycle++;
    if (acc) begin
      acc_q.push_back(aidx);
      acc_cyc.push_back(cycle);
      $display("ACCEPT index %0d cycle %0d", aidx, cycle);
    end
    compare_all();
  endtask

  // Called at posedge+1: assert reset between edges and check outputs at once.
  task automatic async_reset_now(input string tag);
    #3 reset_n = 1'b0;
    #1;
    check_val({tag, "_ev_valid"}, 64'(ev_valid), 64'd0);
    check_val({tag, "_ev_index"}, ev_index, 64'd0);
    check_val({tag, "_cnt"}, 64'(covered_cnt), 64'd0);
    check_val({tag, "_pending_any"}, 64'(pending_any), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    model_reset();
    tick();
    tick();
    #3 reset_n = 1'b1;
    tick();
  endtask

  logic [W-1:0] all_ones;
  int           guard;

  initial begin
    all_ones = '1;
    reset_n  = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    valid    = '0;
    ev_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    #3 reset_n = 1'b1;
    tick();

    // 1: reset with a live event, then release
    enable = 1'b1; ev_ready = 1'b0; valid = W'(1) << 5;
    tick();
    valid = '0;
    tick();
    async_reset_now("t1");
    check_val("t1_done", 64'(done), 64'd0);
    check_val("t1_cnt", 64'(covered_cnt), 64'd0);

    // 2: ordering and counting
    acc_q.delete(); acc_cyc.delete();
    ev_ready = 1'b1;
    valid = (W'(1) << 35) | (W'(1) << 3);
    tick();
    check_val("t2_cnt", 64'(covered_cnt), 64'd2);
    valid = '0;
    tick();
    check_val("t2_first", ev_index, 64'd103);
    tick();
    check_val("t2_second", ev_index, 64'd135);
    check_val("t2_pending_drop", 64'(pending_any), 64'd0);
    tick();
    check_val("t2_idle", 64'(ev_valid), 64'd0);

    // 3: backpressure and dedup
    ev_ready = 1'b0; clear = 1'b1; valid = W'(1) << 3;
    tick();
    clear = 1'b0; valid = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      valid = W'(1) << 3;
      tick();
      check_val("t3_hold_index", ev_index, 64'd103);
      check_val("t3_hold_valid", 64'(ev_valid), 64'd1);
    end
    valid = '0; ev_ready = 1'b1;
    acc_q.delete(); acc_cyc.delete();
    repeat (4) tick();
    check_val("t3_accepts", 64'(acc_q.size()), 64'd1);
    if (acc_q.size() > 0) check_val("t3_index", acc_q[0], 64'd103);

    // 4: full drain
    clear = 1'b1; valid = '0;
    tick();
    clear = 1'b0;
    acc_q.delete(); acc_cyc.delete();
    valid = all_ones;
    tick();
    check_val("t4_cnt", 64'(covered_cnt), 64'd36);
    valid = '0;
    guard = 0;
    while (acc_q.size() < 36 && guard < 80) begin
      tick();
      guard++;
    end
    check_val("t4_accepts", 64'(acc_q.size()), 64'd36);
    check_val("t4_done", 64'(done), 64'd1);
    for (int k = 0; k < acc_q.size(); k++) begin
      check_val("t4_order", acc_q[k], 64'(BASE + k));
      check_val("t4_gapless", 64'(acc_cyc[k]), 64'(acc_cyc[0] + k));
    end

    // 5: clear mid-drain, sink stalls on the clear cycle
    clear = 1'b1; valid = '0;
    tick();
    clear = 1'b0;
    acc_q.delete(); acc_cyc.delete();
    valid = all_ones;
    tick();
    valid = '0;
    guard = 0;
    while (acc_q.size() < 10 && guard < 40) begin
      tick();
      guard++;
    end
    check_val("t5_ten", 64'(acc_q.size()), 64'd10);
    check_val("t5_loaded", ev_index, 64'd110);
    ev_ready = 1'b0; clear = 1'b1; valid = W'(1);
    tick();
    clear = 1'b0; valid = '0; ev_ready = 1'b1;
    acc_q.delete(); acc_cyc.delete();
    repeat (6) tick();
    check_val("t5_accepts", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() >= 2) begin
      check_val("t5_inflight", acc_q[0], 64'd110);
      check_val("t5_rehit", acc_q[1], 64'd100);
    end
    check_val("t5_cnt", 64'(covered_cnt), 64'd1);

    // 6: enable gate, then reset while 102 is presented
    clear = 1'b1; enable = 1'b0; valid = '0;
    tick();
    clear = 1'b0; valid = all_ones;
    repeat (5) tick();
    check_val("t6_gate_cnt", 64'(covered_cnt), 64'd0);
    check_val("t6_gate_valid", 64'(ev_valid), 64'd0);
    enable = 1'b1; valid = W'(8'hFF);
    tick();
    valid = '0;
    guard = 0;
    while (!(ev_valid && ev_index == 64'd102) && guard < 20) begin
      tick();
      guard++;
    end
    check_val("t6_reach_102", ev_index, 64'd102);
    async_reset_now("t6");
    repeat (5) tick();
    check_val("t6_quiet", 64'(ev_valid), 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
      valid    = ($urandom_range(0, 40) == 0) ? all_ones : r[W-1:0];
      enable   = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 25) == 0);
      ev_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    clear = 1'b0; valid = '0; ev_ready = 1'b1;
    repeat (45) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
